// File: rtl/mem_data_port_pkg.sv
// mem_data_port_pkg: state and size encodings shared by mem_data_port and mem_lane_align
package mem_data_port_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR} state_t;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int LANES = 4;
  function automatic logic is_word(input logic [1:0] sz);
    return sz == SZ_W || sz == 2'b11;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: load lane extract/extend and sub-word store merge for a 4-lane word
module mem_lane_align
  import mem_data_port_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic [1:0]               size,
  input  logic [$clog2(LANES)-1:0] lane,
  input  logic                     sgn,
  input  logic [WORD-1:0]          q,
  input  logic [WORD-1:0]          wdata,
  output logic [WORD-1:0]          rdata,
  output logic [WORD-1:0]          mdata
);
  logic [7:0]  b;
  logic [15:0] h;
  // half accesses only look at lane[1], so an odd half address folds onto its aligned half
  always_comb begin
    b = q[lane*8 +: 8];
    h = lane[1] ? q[16 +: 16] : q[0 +: 16];
    rdata = is_word(size) ? q :
            size == SZ_B  ? {{(WORD-8){sgn & b[7]}}, b} : {{(WORD-16){sgn & h[15]}}, h};
    mdata = q;
    if (is_word(size)) mdata = wdata;
    else if (size == SZ_B) mdata[lane*8 +: 8] = wdata[7:0];
    else mdata[lane[1]*16 +: 16] = wdata[15:0];
  end
endmodule

// File: rtl/mem_data_port.sv
// mem_data_port: byte/half/word load-store controller for mem_data (1-cycle registered read)
// MEM_DATA_MISALIGN_CHECK_EN: answer misaligned requests with an error instead of accessing memory
module mem_data_port
  import mem_data_port_pkg::*;
#(
  parameter int ADDR = 16,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [ADDR+1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q
);
  state_t          state;
  logic            we_r, sgn_r, mis;
  logic [1:0]      sz_r, lane_r;
  logic [WORD-1:0] wd_r, ld, md;

  mem_lane_align #(.WORD(WORD)) u_align (
    .size(sz_r), .lane(lane_r), .sgn(sgn_r), .q(mem_q), .wdata(wd_r), .rdata(ld), .mdata(md)
  );

`ifdef MEM_DATA_MISALIGN_CHECK_EN
  assign mis = is_word(req_size) ? |req_addr[1:0] : req_size == SZ_H && req_addr[0];
`else
  assign mis = 1'b0;
`endif
  assign req_ready = state == ST_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      we_r      <= 1'b0;
      sgn_r     <= 1'b0;
      sz_r      <= SZ_B;
      lane_r    <= 2'b00;
      wd_r      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_a     <= '0;
      mem_w     <= 1'b0;
      mem_d     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: if (req_valid) begin
          we_r   <= req_we;
          sgn_r  <= req_signed;
          sz_r   <= req_size;
          lane_r <= req_addr[1:0];
          wd_r   <= req_wdata;
          if (mis) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            mem_a <= req_addr[ADDR+1:2];
            if (req_we && is_word(req_size)) begin
              mem_d <= req_wdata;
              mem_w <= 1'b1;
              state <= ST_WR;
            end else state <= ST_RD;
          end
        end
        ST_RD: state <= ST_CAP;
        // mem_q now holds the addressed word: finish the load or start the merged write
        ST_CAP: if (we_r) begin
          mem_d <= md;
          mem_w <= 1'b1;
          state <= ST_WR;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ld;
          state     <= ST_IDLE;
        end
        ST_WR: begin
          mem_w     <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
